// File: rtl/display_scan_controller.sv
// Eight-digit multiplexed display scanner with a double-buffered frame that commits only at the 7 -> 0 wrap.
// Build option: define GHOST_BLANK_EN to blank the anodes for BLANK_CYCLES at the start of every slot.
module display_scan_controller #(
    parameter int REFRESH_DIV  = 6250,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_en,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic [7:0]  load_mask,
    output logic        load_ready,
    output logic [2:0]  sel,
    output logic [3:0]  digit,
    output logic [7:0]  AN,
    output logic        frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
`ifdef GHOST_BLANK_EN
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`endif

    if (REFRESH_DIV < 4 || REFRESH_DIV > 65535 ||
        BLANK_CYCLES < 1 || BLANK_CYCLES > REFRESH_DIV - 2) begin : g_bad_params
        $error("display_scan_controller: REFRESH_DIV/BLANK_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

    // Handshake: a load transfers on any rising edge where load_valid && load_ready;
    // load_ready is simply "pending slot empty" and never depends on load_valid.

    scan_state_t   state;
    scan_state_t   state_nxt;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          wrap;
    logic          accept;
    logic          commit;
    logic [2:0]    sel_nxt;
    logic [7:0]    mask_nxt;
    logic [31:0]   pend_data;
    logic [7:0]    pend_mask;
    logic          pend_full;
    logic [31:0]   act_data;
    logic [7:0]    act_mask;

    assign tick       = scan_en && (cnt == CNT_MAX);
    assign wrap       = tick && (sel == 3'd7);
    assign commit     = wrap && pend_full;
    assign accept     = load_valid && !pend_full;
    assign load_ready = !pend_full;
    assign sel_nxt    = tick ? sel + 3'd1 : sel;
    assign mask_nxt   = commit ? pend_mask : act_mask;
    assign digit      = act_data[{sel, 2'b00} +: 4];

    always_comb begin
        state_nxt = state;
        if (!scan_en) begin
            state_nxt = ST_OFF;
        end else begin
            case (state)
                ST_OFF:   state_nxt = ST_BLANK;
`ifdef GHOST_BLANK_EN
                // A tick while blanking starts a new slot, which blanks again.
                ST_BLANK: if (!tick && cnt >= BLANK_LAST) state_nxt = ST_SHOW;
                ST_SHOW:  if (tick) state_nxt = ST_BLANK;
`else
                ST_BLANK: state_nxt = ST_SHOW;
                ST_SHOW:  state_nxt = ST_SHOW;
`endif
                default:  state_nxt = ST_OFF;
            endcase
        end
    end

    // AN is registered from next-state values so it lines up with sel and digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            sel        <= 3'd0;
            state      <= ST_OFF;
            pend_data  <= 32'd0;
            pend_mask  <= 8'd0;
            pend_full  <= 1'b0;
            act_data   <= 32'd0;
            act_mask   <= 8'd0;
            frame_done <= 1'b0;
            AN         <= 8'hFF;
        end else begin
            if (scan_en) begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end
            sel        <= sel_nxt;
            state      <= state_nxt;
            frame_done <= wrap;
            if (commit) begin
                act_data  <= pend_data;
                act_mask  <= pend_mask;
                pend_full <= 1'b0;
            end else if (accept) begin
                pend_data <= load_data;
                pend_mask <= load_mask;
                pend_full <= 1'b1;
            end
            if (state_nxt == ST_SHOW) begin
                AN <= ~({7'd0, mask_nxt[sel_nxt]} << sel_nxt);
            end else begin
                AN <= 8'hFF;
            end
        end
    end

endmodule
